wash_cycle_ctrl: RTL and testbench

Wash-cycle sequencer that drives the existing timer block: it programs clk_freq/timer_period, issues timer reset/enable, and consumes done. It steps a washing machine through FILL, WASH, RINSE and SPIN, one timed phase each, and drives the actuator outputs. It sits between the front-panel inputs and the timer instance at the top level.

---
 rtl/wash_cycle_ctrl_if.sv | 26 ++
 rtl/wash_cycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_cycle_ctrl_if.sv
// Timer-side bus between the wash sequencer (master) and the timer block (slave).
// Latency: none, plain wires.
// Backpressure: none; done is a level the master samples when it is ready for it.
interface wash_cycle_ctrl_if;
    logic       timer_enable;
    logic       timer_reset;
    logic       timer_done;
    logic [3:0] clk_freq;
    logic [3:0] timer_period;

    modport master (
        output timer_enable,
        output timer_reset,
        output clk_freq,
        output timer_period,
        input  timer_done
    );

    modport slave (
        input  timer_enable,
        input  timer_reset,
        input  clk_freq,
        input  timer_period,
        output timer_done
    );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Wash sequencer: FILL -> WASH -> RINSE [-> RINSE2] -> SPIN -> COMPLETE, one timer run per phase.
// Latency: a phase lasts timer latency + 1 cycles; start to FILL is one cycle; COMPLETE is one cycle.
// Backpressure: pause or open door freezes the phase and the timer without clearing it.
// DOUBLE_RINSE_EN: when defined, a second rinse phase (state 6) runs between RINSE and SPIN.
module wash_cycle_ctrl #(
    parameter int CLK_FREQ = 5,
    parameter int FILL_T   = 2,
    parameter int WASH_T   = 5,
    parameter int RINSE_T  = 3,
    parameter int SPIN_T   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   door_closed,
    input  logic                   pause,
    wash_cycle_ctrl_if.master      tmr,
    output logic                   water_valve,
    output logic                   motor_on,
    output logic                   drain,
    output logic                   busy,
    output logic                   cycle_done,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        WASH     = 3'd2,
        RINSE    = 3'd3,
        SPIN     = 3'd4,
        COMPLETE = 3'd5,
        RINSE2   = 3'd6
    } state_t;

    // A zero setting would give a timer that never finishes, so it is read as 1.
    localparam logic [3:0] FREQ_C  = (CLK_FREQ == 0) ? 4'd1 : 4'(CLK_FREQ);
    localparam logic [3:0] FILL_C  = (FILL_T   == 0) ? 4'd1 : 4'(FILL_T);
    localparam logic [3:0] WASH_C  = (WASH_T   == 0) ? 4'd1 : 4'(WASH_T);
    localparam logic [3:0] RINSE_C = (RINSE_T  == 0) ? 4'd1 : 4'(RINSE_T);
    localparam logic [3:0] SPIN_C  = (SPIN_T   == 0) ? 4'd1 : 4'(SPIN_T);

    state_t     state_q, state_d;
    // Cycles spent in the current phase, saturating at 2: 0 = arm cycle, 1 = settle cycle,
    // 2 = timer_done may be trusted (anything earlier could be left over from the last phase).
    logic [1:0] age_q, age_d;
    logic       timed;
    logic       hold;
    logic       phase_done;

    assign tmr.clk_freq = FREQ_C;
    assign busy         = (state_q != IDLE);
    assign cycle_done   = (state_q == COMPLETE);
    assign state        = state_q;

    // Classify the current state and decide whether its timer run has validly finished.
    always_comb begin
        timed = 1'b0;
        case (state_q)
            FILL, WASH, RINSE, SPIN: timed = 1'b1;
`ifdef DOUBLE_RINSE_EN
            RINSE2:                  timed = 1'b1;
`endif
            default:                 timed = 1'b0;
        endcase
        hold       = timed && (pause || !door_closed);
        phase_done = timed && !hold && (age_q == 2'd2) && tmr.timer_done;
    end

    // Next-state: phase order, start qualification, and phase-age tracking.
    always_comb begin
        state_d = state_q;
        age_d   = (age_q == 2'd2) ? 2'd2 : age_q + 2'd1;
        case (state_q)
            IDLE:     if (start && door_closed) state_d = FILL;
            FILL:     if (phase_done) state_d = WASH;
            WASH:     if (phase_done) state_d = RINSE;
`ifdef DOUBLE_RINSE_EN
            RINSE:    if (phase_done) state_d = RINSE2;
            RINSE2:   if (phase_done) state_d = SPIN;
`else
            RINSE:    if (phase_done) state_d = SPIN;
`endif
            SPIN:     if (phase_done) state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (state_d != state_q) age_d = 2'd0;
    end

    // Timer programming and actuators; a hold drops everything but lets an arm-cycle clear finish.
    always_comb begin
        tmr.timer_reset  = 1'b1;
        tmr.timer_enable = 1'b0;
        tmr.timer_period = 4'd0;
        water_valve      = 1'b0;
        motor_on         = 1'b0;
        drain            = 1'b0;
        if (timed) begin
            tmr.timer_reset  = (age_q == 2'd0);
            tmr.timer_enable = !hold;
        end
        case (state_q)
            FILL: begin
                tmr.timer_period = FILL_C;
                water_valve      = !hold;
            end
            WASH: begin
                tmr.timer_period = WASH_C;
                motor_on         = !hold;
            end
            RINSE: begin
                tmr.timer_period = RINSE_C;
                water_valve      = !hold;
                motor_on         = !hold;
            end
`ifdef DOUBLE_RINSE_EN
            RINSE2: begin
                tmr.timer_period = RINSE_C;
                water_valve      = !hold;
                motor_on         = !hold;
            end
`endif
            SPIN: begin
                tmr.timer_period = SPIN_C;
                motor_on         = !hold;
                drain            = !hold;
            end
            default: ;
        endcase
    end

    // State and phase-age registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            age_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: vector table, directed full cycles, async reset, random vs. phase model.
// A behavioural timer counts enabled cycles since its last clear; force_done injects stale done.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_wash_cycle_ctrl;
    localparam int CLK_FREQ = 5;
    localparam int FILL_T   = 2;
    localparam int WASH_T   = 5;
    localparam int RINSE_T  = 3;
    localparam int SPIN_T   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       door = 1'b1;
    logic       pause = 1'b0;
    logic       force_done = 1'b0;
    logic       valve, motor, drain, busy, cdone;
    logic [2:0] st;

    wash_cycle_ctrl_if tif();

    wash_cycle_ctrl #(
        .CLK_FREQ(CLK_FREQ), .FILL_T(FILL_T), .WASH_T(WASH_T),
        .RINSE_T(RINSE_T), .SPIN_T(SPIN_T)
    ) u_dut (
        .clk(clk), .reset(rst), .start(start), .door_closed(door), .pause(pause),
        .tmr(tif), .water_valve(valve), .motor_on(motor), .drain(drain),
        .busy(busy), .cycle_done(cdone), .state(st)
    );

    always #5 clk = ~clk;

    // Behavioural timer: done once clk_freq*period enabled cycles have elapsed since the clear.
    int tcnt = 0;
    always @(posedge clk) begin
        if (tif.timer_reset)       tcnt <= 0;
        else if (tif.timer_enable) tcnt <= tcnt + 1;
    end
    assign tif.timer_done = force_done ||
        (!tif.timer_reset && tif.timer_enable &&
         (tcnt >= int'(tif.clk_freq) * int'(tif.timer_period) - 1));

    logic [17:0] obs;
    assign obs = {st, tif.timer_reset, tif.timer_enable, tif.timer_period, tif.clk_freq,
                  valve, motor, drain, busy, cdone};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] in;    // {rst, start, door, pause, force_done}
        logic [2:0] s;
        logic [1:0] rt;    // {timer_reset, timer_enable}
        logic [3:0] per;
        logic [4:0] out;   // {valve, motor, drain, busy, cycle_done}
    } vec_t;

    function automatic vec_t mk(input logic [4:0] in, input logic [2:0] s, input logic [1:0] rt,
                                input logic [3:0] per, input logic [4:0] out);
        vec_t v;
        v.in = in; v.s = s; v.rt = rt; v.per = per; v.out = out;
        return v;
    endfunction

    vec_t tbl[18];

    // ---------------- phase-list reference model ----------------
    int seq[$];

    function automatic int tsec(input int s);
        case (s)
            1:       return FILL_T;
            2:       return WASH_T;
            3, 6:    return RINSE_T;
            4:       return SPIN_T;
            default: return 0;
        endcase
    endfunction

    // pos: -1 idle, 0..len-1 index into the phase list, len = completion cycle.
    function automatic logic [17:0] model_vec(input int pos, input bit arm, input bit p, input bit d);
        logic [2:0] s3;
        logic       held;
        logic [4:0] act;
        int         s;
        if (pos < 0) return {3'd0, 2'b10, 4'd0, 4'(CLK_FREQ), 5'b00000};
        if (pos >= seq.size()) return {3'd5, 2'b10, 4'd0, 4'(CLK_FREQ), 5'b00011};
        s    = seq[pos];
        s3   = 3'(s);
        held = p || !d;
        act  = 5'b00010;
        if (!held) begin
            act[4] = (s == 1 || s == 3 || s == 6);
            act[3] = (s != 1);
            act[2] = (s == 4);
        end
        return {s3, arm, !held, 4'(tsec(s)), 4'(CLK_FREQ), act};
    endfunction

    // ---------------- directed full cycle ----------------
    int exp_order[$];
    int order[$];
    int dur[8];
    int arm_per[8];
    int cd_cnt;
    int pause_bad;

    task automatic run_cycle(input int pause_len, input bit stale);
        int prev, idx, cyc, cur;
        order.delete();
        for (int i = 0; i < 8; i++) begin dur[i] = 0; arm_per[i] = -1; end
        cd_cnt = 0; pause_bad = 0;
        @(posedge clk); #1; start = 1'b1; door = 1'b1; pause = 1'b0; force_done = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        prev = 0; idx = 0; cyc = 0;
        while (cyc < 2000) begin
            cur = int'(st);
            if (cur != prev) begin
                order.push_back(cur);
                idx = 0;
                arm_per[cur] = int'(tif.timer_period);
            end else begin
                idx++;
            end
            dur[cur]++;
            pause = (cur == 2 && idx >= 5 && idx < 5 + pause_len);
            force_done = stale && ((cur == 1 && idx >= CLK_FREQ * FILL_T) || (cur == 2 && idx < 2));
            @(negedge clk);
            if (pause && (st !== 3'd2 || tif.timer_enable !== 1'b0 || motor !== 1'b0 ||
                          tif.timer_reset !== 1'b0)) pause_bad++;
            if (cdone) cd_cnt++;
            prev = cur;
            if (cur == 0 && order.size() > 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        pause = 1'b0; force_done = 1'b0;
        if (cyc >= 2000) chk("cycle_timeout", 1, 0);
        chk("order_len", order.size(), exp_order.size());
        for (int i = 0; i < order.size() && i < exp_order.size(); i++)
            chk($sformatf("order[%0d]", i), order[i], exp_order[i]);
        foreach (seq[i]) begin
            chk($sformatf("dur_s%0d", seq[i]), dur[seq[i]],
                CLK_FREQ * tsec(seq[i]) + 1 + ((seq[i] == 2) ? pause_len : 0));
            chk($sformatf("period_s%0d", seq[i]), arm_per[seq[i]], tsec(seq[i]));
        end
        chk("complete_len", dur[5], 1);
        chk("cycle_done_pulses", cd_cnt, 1);
        chk("pause_hold", pause_bad, 0);
    endtask

    initial begin
        int pos, left, k;
        bit arm;

`ifdef DOUBLE_RINSE_EN
        seq = '{1, 2, 3, 6, 4};
        exp_order = '{1, 2, 3, 6, 4, 5, 0};
`else
        seq = '{1, 2, 3, 4};
        exp_order = '{1, 2, 3, 4, 5, 0};
`endif

        tbl[0]  = mk(5'b10100, 3'd0, 2'b10, 4'd0, 5'b00000);  // reset
        tbl[1]  = mk(5'b01000, 3'd0, 2'b10, 4'd0, 5'b00000);  // start, door open
        tbl[2]  = mk(5'b00100, 3'd0, 2'b10, 4'd0, 5'b00000);  // ignored
        tbl[3]  = mk(5'b01100, 3'd0, 2'b10, 4'd0, 5'b00000);  // start, door closed
        tbl[4]  = mk(5'b00100, 3'd1, 2'b11, 4'd2, 5'b10010);  // FILL arm
        tbl[5]  = mk(5'b00100, 3'd1, 2'b01, 4'd2, 5'b10010);
        tbl[6]  = mk(5'b00110, 3'd1, 2'b00, 4'd2, 5'b00010);  // pause
        tbl[7]  = mk(5'b00000, 3'd1, 2'b00, 4'd2, 5'b00010);  // door open
        tbl[8]  = mk(5'b01100, 3'd1, 2'b01, 4'd2, 5'b10010);  // start while busy
        tbl[9]  = mk(5'b10100, 3'd0, 2'b10, 4'd0, 5'b00000);  // async reset mid-FILL
        tbl[10] = mk(5'b01101, 3'd0, 2'b10, 4'd0, 5'b00000);  // start + done in IDLE
        tbl[11] = mk(5'b00101, 3'd1, 2'b11, 4'd2, 5'b10010);  // stale done, arm
        tbl[12] = mk(5'b00101, 3'd1, 2'b01, 4'd2, 5'b10010);  // stale done, settle
        tbl[13] = mk(5'b00100, 3'd1, 2'b01, 4'd2, 5'b10010);  // still FILL
        tbl[14] = mk(5'b10100, 3'd0, 2'b10, 4'd0, 5'b00000);
        tbl[15] = mk(5'b01100, 3'd0, 2'b10, 4'd0, 5'b00000);
        tbl[16] = mk(5'b00110, 3'd1, 2'b10, 4'd2, 5'b00010);  // pause on arm cycle
        tbl[17] = mk(5'b00100, 3'd1, 2'b01, 4'd2, 5'b10010);

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            {rst, start, door, pause, force_done} = tbl[i].in;
            @(negedge clk);
            chk($sformatf("table[%0d]", i), obs,
                {tbl[i].s, tbl[i].rt, tbl[i].per, 4'(CLK_FREQ), tbl[i].out});
        end

        @(posedge clk); #1; rst = 1'b1; start = 1'b0; pause = 1'b0; force_done = 1'b0; door = 1'b1;
        @(posedge clk); #1; rst = 1'b0;

        run_cycle(0, 1'b0);
        run_cycle(7, 1'b0);
        run_cycle(0, 1'b1);

        // Asynchronous reset between edges in the middle of WASH.
        @(posedge clk); #1; start = 1'b1; door = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        while (st !== 3'd2 && k < 100) begin @(posedge clk); #1; k++; end
        chk("reach_wash", st, 3'd2);
        repeat (3) @(posedge clk);
        @(negedge clk); #2; rst = 1'b1;
        #1 chk("async_reset_mid_wash", obs, {3'd0, 2'b10, 4'd0, 4'(CLK_FREQ), 5'b00000});

        // Randomised traffic against the phase-list model.
        @(posedge clk); #1; rst = 1'b0;
        pos = -1; arm = 1'b0; left = 0;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(7) == 0);
            door  = ($urandom_range(9) != 0);
            pause = ($urandom_range(7) == 0);
            @(negedge clk);
            chk($sformatf("random[%0d]", i), obs, model_vec(pos, arm, pause, door));
            if (pos < 0) begin
                if (start && door) begin pos = 0; arm = 1'b1; left = CLK_FREQ * tsec(seq[0]); end
            end else if (pos >= seq.size()) begin
                pos = -1;
            end else if (arm) begin
                arm = 1'b0;
            end else if (!(pause || !door)) begin
                left--;
                if (left == 0) begin
                    pos++;
                    arm = 1'b1;
                    if (pos < seq.size()) left = CLK_FREQ * tsec(seq[pos]);
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
